// File: rtl/float_threshold_comparator_pkg.sv
// Shared types and helpers for the floating-point threshold comparator:
// relation-mode encoding, result bundle and the mode-evaluation function.
package float_cmp_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_GT = 3'd0,
    MODE_GE = 3'd1,
    MODE_LT = 3'd2,
    MODE_LE = 3'd3,
    MODE_EQ = 3'd4,
    MODE_NE = 3'd5
  } cmp_mode_e;

  typedef struct packed {
    logic result;
    logic is_higher;
    logic unordered;
  } cmp_res_t;

  // Unordered operands only satisfy NE; reserved encodings never hit.
  function automatic logic eval_mode(input logic [MODE_W-1:0] mode,
                                     input logic lt,
                                     input logic eq,
                                     input logic gt,
                                     input logic unord);
    logic r;
    r = 1'b0;
    case (mode)
      MODE_GT: r = gt;
      MODE_GE: r = gt | eq;
      MODE_LT: r = lt;
      MODE_LE: r = lt | eq;
      MODE_EQ: r = eq;
      MODE_NE: r = ~eq;
      default: r = 1'b0;
    endcase
    if (unord) r = (mode == MODE_NE);
    return r;
  endfunction

endpackage

// File: rtl/float_threshold_comparator_if.sv
// Sample-in / result-out stream bundle of the threshold comparator.
// master = producer/consumer side, slave = comparator side.
interface float_threshold_comparator_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic                         in_valid;
  logic                         in_ready;
  logic [W-1:0]                 a;
  logic [float_cmp_pkg::MODE_W-1:0] mode;
  logic                         out_valid;
  logic                         out_ready;
  logic                         result;
  logic                         is_higher;
  logic                         unordered;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, result, is_higher, unordered
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, result, is_higher, unordered
  );

endinterface

// File: rtl/float_order_key.sv
// Maps a sign-magnitude float pattern to an unsigned-comparable key and
// classifies it as NaN or zero.
module float_order_key #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output logic [EXP_W+MAN_W:0] key_o,
  output logic                 is_nan_o,
  output logic                 is_zero_o
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = x_i[W-2 -: EXP_W];
  assign man_f = x_i[MAN_W-1:0];

  assign is_nan_o  = (&exp_f) & (|man_f);
  assign is_zero_o = (exp_f == '0) & (man_f == '0);

  // Negatives invert so larger magnitude sorts lower; positives sit above them.
  assign key_o = x_i[W-1] ? ~x_i : {1'b1, x_i[W-2:0]};

endmodule

// File: rtl/float_threshold_comparator.sv
// Two-stage pipelined comparator of a float sample stream against a loadable
// threshold, with valid/ready flow control and a saturating hit counter.
module float_threshold_comparator
  import float_cmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     thr_load,
  input  logic [EXP_W+MAN_W:0]     thr_value,
  input  logic                     count_clear,
  output logic [CNT_W-1:0]         hit_count,
  float_threshold_comparator_if.slave bus
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic             advance;
  logic             accept;

  logic [W-1:0]     thr_q;

  logic [W-1:0]     a_key, t_key;
  logic             a_nan, t_nan, a_zero, t_zero;

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_key_q, s1_t_key_q;
  logic             s1_unord_q;
  logic             s1_both_zero_q;
  logic [MODE_W-1:0] s1_mode_q;

  logic             eq, gt, lt;
  cmp_res_t         res_d, res_q;
  logic             out_valid_q;

  logic [CNT_W-1:0] hit_count_d, hit_count_q;

  // The whole pipe moves together; a full output stage blocks everything.
  assign advance      = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & advance;
  assign bus.in_ready = advance;

  float_order_key #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_key_a (
    .x_i       (bus.a),
    .key_o     (a_key),
    .is_nan_o  (a_nan),
    .is_zero_o (a_zero)
  );

  float_order_key #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_key_t (
    .x_i       (thr_q),
    .key_o     (t_key),
    .is_nan_o  (t_nan),
    .is_zero_o (t_zero)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    eq = s1_both_zero_q | (s1_a_key_q == s1_t_key_q);
    gt = ~eq & (s1_a_key_q > s1_t_key_q);
    lt = ~eq & ~gt;
    res_d.unordered = s1_unord_q;
    res_d.is_higher = gt & ~s1_unord_q;
    res_d.result    = eval_mode(s1_mode_q, lt, eq, gt, s1_unord_q);
  end

  // Clear outranks a same-cycle increment; the counter sticks at all-ones.
  always_comb begin
    hit_count_d = hit_count_q;
    if (count_clear) begin
      hit_count_d = '0;
    end else if (out_valid_q && bus.out_ready && res_q.result && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thr_q       <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      hit_count_q <= '0;
    end else begin
      if (thr_load) thr_q <= thr_value;
      if (advance) begin
        s1_valid_q  <= accept;
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) res_q <= res_d;
      end
      hit_count_q <= hit_count_d;
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid_q, so it needs no reset;
  // leaving it unreset keeps the reset net off this wide datapath.
  always_ff @(posedge clock) begin
    if (accept) begin
      s1_a_key_q     <= a_key;
      s1_t_key_q     <= t_key;
      s1_unord_q     <= a_nan | t_nan;
      s1_both_zero_q <= a_zero & t_zero;
      s1_mode_q      <= bus.mode;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q.result;
  assign bus.is_higher = res_q.is_higher;
  assign bus.unordered = res_q.unordered;
  assign hit_count     = hit_count_q;

endmodule

// File: tb/tb_float_threshold_comparator.sv
// Scoreboard bench: single precision (A) and half precision with a 2-bit
// counter (B) run side by side off one clock.
module tb_float_threshold_comparator;
  import float_cmp_pkg::*;

  typedef struct {
    logic [2:0] want;
    int         acc;
    bit         strict;
  } sb_t;

  logic        clk;
  logic        rst_n_v     [2];
  logic        in_valid_v  [2];
  logic [31:0] a_v         [2];
  logic [2:0]  mode_v      [2];
  logic        out_ready_v [2];
  logic        thr_load_v  [2];
  logic [31:0] thr_value_v [2];
  logic        count_clear_v [2];

  logic [15:0] hit_a;
  logic [1:0]  hit_b;

  int          ew   [2] = '{8, 5};
  int          mw   [2] = '{23, 10};
  int          cmax [2] = '{65535, 3};

  logic [31:0] thr_m [2];
  int          hit_m [2];
  bit          acc_v [2];
  sb_t         q0[$];
  sb_t         q1[$];
  int          total, bad, cyc;
  bit          strict_v;

  float_threshold_comparator_if #(.EXP_W(8), .MAN_W(23)) bus_a ();
  float_threshold_comparator_if #(.EXP_W(5), .MAN_W(10)) bus_b ();

  assign bus_a.in_valid  = in_valid_v[0];
  assign bus_a.a         = a_v[0];
  assign bus_a.mode      = mode_v[0];
  assign bus_a.out_ready = out_ready_v[0];
  assign bus_b.in_valid  = in_valid_v[1];
  assign bus_b.a         = a_v[1][15:0];
  assign bus_b.mode      = mode_v[1];
  assign bus_b.out_ready = out_ready_v[1];

  float_threshold_comparator #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) dut_a (
    .clock       (clk),
    .reset_n     (rst_n_v[0]),
    .thr_load    (thr_load_v[0]),
    .thr_value   (thr_value_v[0]),
    .count_clear (count_clear_v[0]),
    .hit_count   (hit_a),
    .bus         (bus_a)
  );

  float_threshold_comparator #(.EXP_W(5), .MAN_W(10), .CNT_W(2)) dut_b (
    .clock       (clk),
    .reset_n     (rst_n_v[1]),
    .thr_load    (thr_load_v[1]),
    .thr_value   (thr_value_v[1][15:0]),
    .count_clear (count_clear_v[1]),
    .hit_count   (hit_b),
    .bus         (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic string tag(input int i, input string s);
    return $sformatf("%s.%s", (i == 0) ? "A" : "B", s);
  endfunction

  // Value-level reference: sign/magnitude ordering with explicit zero/NaN cases.
  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] t,
                                         input logic [2:0] md, input int e_w, input int m_w);
    logic [31:0] mag_mask, exp_ones, man_mask, xm, tm;
    logic        xs, ts, xn, tn, r;
    int          ord;
    mag_mask = (32'd1 << (e_w + m_w)) - 32'd1;
    exp_ones = (32'd1 << e_w) - 32'd1;
    man_mask = (32'd1 << m_w) - 32'd1;
    xs = x[e_w+m_w];
    ts = t[e_w+m_w];
    xm = x & mag_mask;
    tm = t & mag_mask;
    xn = ((xm >> m_w) == exp_ones) && ((xm & man_mask) != 0);
    tn = ((tm >> m_w) == exp_ones) && ((tm & man_mask) != 0);
    if (xm == 0 && tm == 0)  ord = 0;
    else if (xs != ts)       ord = xs ? -1 : 1;
    else if (xm == tm)       ord = 0;
    else if (xm > tm)        ord = xs ? -1 : 1;
    else                     ord = xs ? 1 : -1;
    if (xn || tn) return {md == 3'd5, 1'b0, 1'b1};
    case (md)
      3'd0:    r = (ord > 0);
      3'd1:    r = (ord >= 0);
      3'd2:    r = (ord < 0);
      3'd3:    r = (ord <= 0);
      3'd4:    r = (ord == 0);
      3'd5:    r = (ord != 0);
      default: r = 1'b0;
    endcase
    return {r, ord > 0, 1'b0};
  endfunction

  function automatic int q_size(input int i);
    if (i == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic sb_t q_front(input int i);
    if (i == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic q_pop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic q_push(input int i, input sb_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called right after a falling edge with inputs already driven: observe,
  // update the models for the coming rising edge, then wait for the next fall.
  task automatic cycle();
    logic       ov, ir;
    logic [2:0] obs;
    int         hc;
    sb_t        e;
    bit         dlv;
    logic       dres;
    #1;
    for (int i = 0; i < 2; i++) begin
      acc_v[i] = 1'b0;
      if (!rst_n_v[i]) continue;
      if (i == 0) begin
        ov = bus_a.out_valid; ir = bus_a.in_ready; hc = int'(hit_a);
        obs = {bus_a.result, bus_a.is_higher, bus_a.unordered};
      end else begin
        ov = bus_b.out_valid; ir = bus_b.in_ready; hc = int'(hit_b);
        obs = {bus_b.result, bus_b.is_higher, bus_b.unordered};
      end
      check(tag(i, "hit_count"), hc, hit_m[i]);
      dlv = 1'b0;
      dres = 1'b0;
      if (ov) begin
        if (q_size(i) == 0) begin
          check(tag(i, "spurious_out_valid"), ov, 1'b0);
        end else begin
          e = q_front(i);
          check(tag(i, "res{r,hi,un}"), obs, e.want);
          if (!out_ready_v[i]) check(tag(i, "in_ready_stall"), ir, 1'b0);
          if (out_ready_v[i]) begin
            if (e.strict) check(tag(i, "latency"), cyc - e.acc, 2);
            q_pop(i);
            dlv = 1'b1;
            dres = e.want[2];
          end
        end
      end
      if (in_valid_v[i] && ir) begin
        acc_v[i] = 1'b1;
        e.want   = ref_cmp(a_v[i], thr_m[i], mode_v[i], ew[i], mw[i]);
        e.acc    = cyc;
        e.strict = strict_v;
        q_push(i, e);
      end
      if (thr_load_v[i]) thr_m[i] = thr_value_v[i];
      if (count_clear_v[i])                       hit_m[i] = 0;
      else if (dlv && dres && hit_m[i] < cmax[i]) hit_m[i]++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int i, input logic [31:0] av, input logic [2:0] md);
    int n;
    n = 0;
    in_valid_v[i] = 1'b1;
    a_v[i]        = av;
    mode_v[i]     = md;
    do begin
      cycle();
      n++;
    end while (!acc_v[i] && n < 20);
    if (!acc_v[i]) check(tag(i, "send_accept"), acc_v[i], 1'b1);
  endtask

  task automatic drain(input int i, input int n);
    in_valid_v[i] = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; strict_v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0; in_valid_v[i] = 1'b0; a_v[i] = '0; mode_v[i] = '0;
      out_ready_v[i] = 1'b1; thr_load_v[i] = 1'b0; thr_value_v[i] = '0;
      count_clear_v[i] = 1'b0; thr_m[i] = '0; hit_m[i] = 0; acc_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("A.rst_out_valid", bus_a.out_valid, 1'b0);
    check("A.rst_result", {bus_a.result, bus_a.is_higher, bus_a.unordered}, 3'b000);
    check("A.rst_hit", hit_a, 0);
    check("B.rst_out_valid", bus_b.out_valid, 1'b0);
    check("B.rst_hit", hit_b, 0);
    rst_n_v[0] = 1'b1;
    rst_n_v[1] = 1'b1;
    cycle();
    check("A.in_ready_idle", bus_a.in_ready, 1'b1);

    // Negative sample against the +0 reset threshold.
    send(0, 32'hBE20_0000, MODE_GT);
    send(0, 32'hBE20_0000, MODE_LT);
    drain(0, 4);
    check("A.hit_after_lt", hit_a, 1);

    // Load coincident with accept uses the old threshold.
    thr_load_v[0] = 1'b1; thr_value_v[0] = 32'h3F80_0000;
    send(0, 32'h4000_0000, MODE_GT);
    thr_load_v[0] = 1'b0;
    send(0, 32'h3F00_0000, MODE_GT);
    drain(0, 4);

    // Signed zeros, NaN, reserved mode, subnormals against +0.
    thr_load_v[0] = 1'b1; thr_value_v[0] = 32'h0000_0000;
    in_valid_v[0] = 1'b0;
    cycle();
    thr_load_v[0] = 1'b0;
    send(0, 32'h8000_0000, MODE_EQ);
    send(0, 32'h8000_0000, MODE_GT);
    send(0, 32'h8000_0000, MODE_GE);
    send(0, 32'h7FC0_0000, MODE_NE);
    send(0, 32'h7FC0_0000, MODE_EQ);
    send(0, 32'h3F80_0000, 3'd6);
    send(0, 32'h0000_0001, MODE_GT);
    send(0, 32'h8000_0001, MODE_LT);
    drain(0, 4);

    // Back-to-back stream with a three-cycle output stall in the middle.
    strict_v = 1'b0;
    send(0, 32'h3F80_0000, MODE_GT);
    send(0, 32'hBF80_0000, MODE_LT);
    a_v[0] = 32'h4040_0000; mode_v[0] = MODE_GE;
    out_ready_v[0] = 1'b0;
    repeat (3) cycle();
    check("A.stall_held_out_valid", bus_a.out_valid, 1'b1);
    out_ready_v[0] = 1'b1;
    send(0, 32'h4040_0000, MODE_GE);
    send(0, 32'hC040_0000, MODE_LE);
    drain(0, 5);
    strict_v = 1'b1;

    // Half precision: infinities against 1.0, then counter saturation.
    thr_load_v[1] = 1'b1; thr_value_v[1] = 32'h0000_3C00;
    in_valid_v[1] = 1'b0;
    cycle();
    thr_load_v[1] = 1'b0;
    send(1, 32'h0000_7C00, MODE_GT);
    send(1, 32'h0000_FC00, MODE_LT);
    send(1, 32'h0000_7C00, MODE_GE);
    send(1, 32'h0000_7C00, MODE_NE);
    send(1, 32'h0000_FC00, MODE_LE);
    drain(1, 4);
    check("B.hit_saturated", hit_b, 2'd3);

    // Clear in the same cycle a hit is delivered.
    send(1, 32'h0000_7C00, MODE_GT);
    in_valid_v[1] = 1'b0;
    cycle();
    count_clear_v[1] = 1'b1;
    check("B.clear_aligned_valid", bus_b.out_valid, 1'b1);
    cycle();
    count_clear_v[1] = 1'b0;
    cycle();
    check("B.hit_cleared", hit_b, 2'd0);

    // Reset with two samples in flight discards them.
    send(1, 32'h0000_7C00, MODE_GT);
    send(1, 32'h0000_FC00, MODE_LT);
    in_valid_v[1] = 1'b0;
    rst_n_v[1] = 1'b0;
    #1;
    check("B.rst_mid_out_valid", bus_b.out_valid, 1'b0);
    q1.delete();
    thr_m[1] = '0;
    hit_m[1] = 0;
    cycle();
    cycle();
    rst_n_v[1] = 1'b1;
    drain(1, 6);
    check("B.post_rst_out_valid", bus_b.out_valid, 1'b0);
    check("B.post_rst_in_ready", bus_b.in_ready, 1'b1);

    check("A.sb_empty", q_size(0), 0);
    check("B.sb_empty", q_size(1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_threshold_comparator.md
Name: float_threshold_comparator

Overview:
- Parametrised, pipelined IEEE-754-style comparator. Compares a stream of floating-point samples against a runtime-loadable threshold.
- Selectable relation mode, with NaN/zero handling and valid/ready flow control on both sides.
- Produces a saturating hit counter.
- Next-generation replacement for the fixed 32-bit single-flag comparator. Sits between sample producers (datapath/FPU outputs) and control logic that needs threshold events.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width.
- W = 1+EXP_W+MAN_W, derived localparam (not overridable).
- CNT_W, 16, width of hit counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- thr_load  in  1  load thr_value into threshold register this edge.
- thr_value  in  W  new threshold bit pattern.
- in_valid  in  1  sample a/mode valid.
- in_ready  out  1  block can accept sample this cycle.
- a  in  W  sample bit pattern.
- mode  in  3  relation for this sample: 0 GT, 1 GE, 2 LT, 3 LE, 4 EQ, 5 NE, 6-7 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  1  a <mode> threshold.
- is_higher  out  1  a > threshold, independent of mode.
- unordered  out  1  a or threshold is NaN.
- count_clear  in  1  synchronous clear of hit_count.
- hit_count  out  CNT_W  saturating count of delivered results with result=1.

Behaviour:
- Reset (async assert, sync-released by system):
  - threshold = 0 (+0.0); both stage valids = 0.
  - out_valid, result, is_higher, unordered = 0; hit_count = 0.
- Pipeline: 2 register stages.
  - Global advance = !out_valid || out_ready; in_ready = advance (combinational, no dependency on in_valid).
  - Accept on in_valid && in_ready.
  - Latency: exactly 2 cycles from accept edge to out_valid when out_ready held 1. Throughput 1/cycle.
- Stage 1 captures a, mode and the current threshold register value together. Later thr_load never affects in-flight samples.
- thr_load: threshold updates at the edge. A sample accepted on that same edge uses the OLD threshold. Load is permitted while stalled.
- Classification per operand:
  - NaN: exp all ones, man != 0.
  - Zero: exp = 0, man = 0.
- Order key: sign=1 -> ~x; sign=0 -> x with MSB set. Compare keys unsigned.
- +0 and -0 are equal. Infinities order normally. Subnormals order by bit pattern.
- Either operand NaN:
  - unordered = 1, is_higher = 0.
  - result = 1 only for NE, 0 for all other modes.
- Reserved modes: result = 0; is_higher/unordered still valid.
- Stall: when out_valid && !out_ready, all stage registers hold and outputs stay stable.
- Bubbles: drain normally; out_valid drops when no data.
- hit_count:
  - +1 on out_valid && out_ready && result; saturates at 2^CNT_W-1.
  - count_clear wins over a same-cycle increment (result 0).
- Reset mid-operation: in-flight samples discarded, no output produced.

Decomposition:
- Package float_cmp_pkg:
  - mode constants: MODE_GT..MODE_NE.
  - mode width = 3.
  - function for mode evaluation from {lt, eq, gt, unord}.
- One combinational sub-module float_order_key, parametrised by EXP_W/MAN_W. Outputs key, is_nan, is_zero. Instantiated twice in stage 1 (sample and threshold).
- Top holds the pipeline, handshake, threshold register and counter.

Test Plan:
- Reset, threshold 0; a=0xBE200000 (-0.15625), mode GT, out_ready=1 -> out_valid 2 cycles after accept; result=0, is_higher=0. Same sample with mode LT -> result=1, hit_count=1.
- thr_load 0x3F800000 (1.0) in the same cycle as accepting a=0x40000000 (2.0, GT) -> result=1 (old threshold 0). Next sample 0x3F000000 (0.5, GT) -> result=0.
- Threshold 0x00000000, a=0x80000000 (-0.0): EQ -> 1, GT -> 0, GE -> 1. a=0x7FC00000 (NaN), NE -> result=1, unordered=1; EQ -> result=0.
- Stream 4 samples back-to-back; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while out_valid, outputs stable. All 4 results delivered in order, none lost or duplicated.
- CNT_W=2: deliver 5 results with result=1 -> hit_count saturates at 3. Assert count_clear in the same cycle as a hit delivery -> hit_count=0.
- EXP_W=5, MAN_W=10 (half): threshold 0x3C00 (1.0), a=0x7C00 (+inf) GT -> 1; a=0xFC00 (-inf) LT -> 1. Assert reset_n low with 2 samples in flight -> out_valid=0 immediately, no output afterwards.
